// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled digit stepping, anti-ghost guard,
// frame-synchronous value latch, leading-zero blanking, decimal points and hex/decimal decode.
module fnd_scan_ctrl #(
  parameter int DIGITS  = 4,
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int GUARD   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         load,
  input  logic [4*DIGITS-1:0]          value,
  input  logic [DIGITS-1:0]            dp_en,
  input  logic                         hex_mode,
  input  logic                         lz_blank,
  output logic [7:0]                   fnd_data,
  output logic [DIGITS-1:0]            fnd_com,
  output logic [$clog2(DIGITS)-1:0]    digit_idx,
  output logic                         frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = $clog2(DIGITS);
  localparam int GW  = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD);

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                hex;
    logic                lz;
  } cfg_t;

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [GW-1:0]     guard_q, guard_d;
  cfg_t              stage_q, stage_d;
  cfg_t              shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              active_q, active_d;
  logic [7:0]        data_q, data_d;
  logic [DIGITS-1:0] com_q, com_d;
  logic              frame_q, frame_d;

  logic       tick;
  logic       wrap;
  logic [3:0] nib;
  logic       dp_sel;
  logic       tail_nonzero;
  logic [7:0] pat_next;

  function automatic logic [7:0] seg_lut(input logic [3:0] n, input logic hex);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    if (!hex && n > 4'd9) s = 8'hBF;
    return s;
  endfunction

  // Staging only reaches the shadow on a wrap, so every frame shows a single load.
  always_comb begin
    tick      = (presc_q == DIV_LAST);
    wrap      = tick && (idx_q == IDX_LAST);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    guard_d   = tick ? GUARD_INIT : ((guard_q != '0) ? guard_q - 1'b1 : guard_q);
    stage_d   = load ? cfg_t'{value, dp_en, hex_mode, lz_blank} : stage_q;
    pending_d = load ? 1'b1 : (wrap ? 1'b0 : pending_q);
    shadow_d  = (wrap && pending_q) ? stage_q : shadow_q;
    frame_d   = wrap;
  end

  // Decode uses the next shadow so digit 0 of a new frame already sees the new data.
  always_comb begin
    nib          = 4'd0;
    dp_sel       = 1'b0;
    tail_nonzero = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == idx_d) begin
        nib    = shadow_d.value[k*4 +: 4];
        dp_sel = shadow_d.dp[k];
      end
      if (k >= int'(idx_d) && shadow_d.value[k*4 +: 4] != 4'd0) tail_nonzero = 1'b1;
    end
    if (shadow_d.lz && idx_d != '0 && !tail_nonzero) pat_next = 8'hFF;
    else pat_next = seg_lut(nib, shadow_d.hex);
    if (dp_sel) pat_next[7] = 1'b0;
  end

  always_comb begin
    if (!enable) begin
      active_d = 1'b0;
      data_d   = 8'hFF;
    end else if (tick) begin
      active_d = 1'b1;
      data_d   = pat_next;
    end else begin
      active_d = active_q;
      data_d   = data_q;
    end
    com_d = '1;
    if (enable && active_d && !tick && guard_d == '0) com_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      guard_q   <= '0;
      stage_q   <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      active_q  <= 1'b0;
      data_q    <= 8'hFF;
      com_q     <= '1;
      frame_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      guard_q   <= guard_d;
      stage_q   <= stage_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      data_q    <= data_d;
      com_q     <= com_d;
      frame_q   <= frame_d;
    end
  end

  assign fnd_data   = data_q;
  assign fnd_com    = com_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: expected frames are queued when a load is driven
// and compared digit by digit as the scan selects each common.
module tb_fnd_scan_ctrl;

   localparam int DIGITS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dpEn = '0;
   logic        hexMode = 1'b0;
   logic        lzBlank = 1'b0;
   logic [7:0]  fndData;
   logic [3:0]  fndCom;
   logic [1:0]  digitIdx;
   logic        frameDone;

   int assertCount = 0;
   int failCount = 0;

   int          qFrame[$];
   logic [31:0] qPat[$];
   logic [31:0] curPat = 32'hC0C0C0C0;
   int          frameNum = 0;
   longint      cycle = 0;
   longint      stepCycle = 0;
   longint      lastFrameCycle = 0;
   bit          haveFrame = 0;
   bit          armed = 0;
   bit          monOn = 0;
   logic [7:0]  prevData;
   logic [3:0]  prevCom;
   logic [1:0]  prevIdx;
   logic [3:0]  expCom;
   logic [1:0]  idxSnap;

   fnd_scan_ctrl #(.DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100), .GUARD(2)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
      .dp_en(dpEn), .hex_mode(hexMode), .lz_blank(lzBlank),
      .fnd_data(fndData), .fnd_com(fndCom), .digit_idx(digitIdx), .frame_done(frameDone)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Monitor samples 1 time unit after each rising edge and pops expected frames at each wrap.
   always @(posedge clk) begin
      #1;
      cycle++;
      if (monOn) begin
         if (fndData !== prevData) checkOutput("dataChangeComsOff", fndCom, 4'hF);
         if (fndCom !== 4'hF) checkOutput("comOneHot", $countones(~fndCom), 1);
         if (digitIdx !== prevIdx) begin
            checkOutput("idxStep", digitIdx, 2'(prevIdx + 2'd1));
            stepCycle = cycle;
            if (enable) armed = 1;
         end
         if (!enable) begin
            armed = 0;
            checkOutput("disabledOff", {fndCom, fndData}, 12'hFFF);
         end else if (!armed) begin
            checkOutput("offUntilStep", fndCom, 4'hF);
         end
         if (frameDone) begin
            checkOutput("frameIdx", digitIdx, 0);
            if (haveFrame) checkOutput("framePeriod", 32'(cycle - lastFrameCycle), 40);
            haveFrame = 1;
            lastFrameCycle = cycle;
            frameNum++;
            if (qFrame.size() > 0 && qFrame[0] == frameNum) begin
               void'(qFrame.pop_front());
               curPat = qPat.pop_front();
            end
         end
         if (prevCom === 4'hF && fndCom !== 4'hF) begin
            expCom = ~(4'b0001 << digitIdx);
            checkOutput("comSelect", fndCom, expCom);
            checkOutput("guardDelay", 32'(cycle - stepCycle), 2);
            checkOutput($sformatf("digit%0d", digitIdx), fndData, curPat[digitIdx*8 +: 8]);
         end
      end
      prevData = fndData;
      prevCom  = fndCom;
      prevIdx  = digitIdx;
   end

   task automatic waitFrameStart();
      int budget;
      budget = 0;
      do begin
         @(negedge clk);
         budget++;
      end while (!frameDone && budget < 100);
      if (!frameDone) checkOutput("frameTimeout", 0, 1);
   endtask

   task automatic waitFrames(input int n);
      repeat (n) waitFrameStart();
   endtask

   task automatic loadCfg(input logic [15:0] v, input logic [3:0] dp, input logic hx, input logic lz);
      value = v; dpEn = dp; hexMode = hx; lzBlank = lz; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic pushExpect(input int applyFrame, input logic [31:0] pat);
      qFrame.push_back(applyFrame);
      qPat.push_back(pat);
   endtask

   task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dp, input logic hx,
                                input logic lz, input logic [31:0] pat);
      waitFrameStart();
      repeat (5) @(negedge clk);
      pushExpect(frameNum + 1, pat);
      loadCfg(v, dp, hx, lz);
      waitFrames(2);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] fnd_scan_ctrl bench start");
      enable = 1'b1;
      #12;
      checkOutput("resetCom", fndCom, 4'hF);
      checkOutput("resetData", fndData, 8'hFF);
      checkOutput("resetFrameDone", frameDone, 0);
      checkOutput("resetIdx", digitIdx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      prevData = fndData; prevCom = fndCom; prevIdx = digitIdx;
      monOn = 1;

      // Free-running scan of the cleared shadow.
      waitFrames(3);

      applyStimulus(16'h12AF, 4'b0000, 1'b1, 1'b0, 32'hF9A4888E);
      applyStimulus(16'h12AF, 4'b0000, 1'b0, 1'b0, 32'hF9A4BFBF);
      applyStimulus(16'h0050, 4'b0100, 1'b0, 1'b1, 32'hFF7F92C0);
      applyStimulus(16'h0000, 4'b0000, 1'b0, 1'b1, 32'hFFFFFFC0);

      // Two loads in one frame then one on the wrap edge.
      waitFrameStart();
      repeat (5) @(negedge clk);
      loadCfg(16'h1111, 4'b0000, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      pushExpect(frameNum + 1, 32'hA4A4A4A4);
      loadCfg(16'h2222, 4'b0000, 1'b0, 1'b0);
      repeat (27) @(negedge clk);
      pushExpect(frameNum + 2, 32'hB0B0B0B0);
      loadCfg(16'h3333, 4'b0000, 1'b0, 1'b0);
      waitFrames(3);
      checkOutput("queueDrained", qFrame.size(), 0);

      // Disable mid-digit; the index must keep stepping.
      waitFrameStart();
      repeat (25) @(negedge clk);
      idxSnap = digitIdx;
      enable = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("idxRunsDisabled", digitIdx, 2'(idxSnap + 2'd2));
      enable = 1'b1;
      waitFrames(2);

      // Reset during a guard window clears the shadow.
      begin
         int budget;
         budget = 0;
         idxSnap = digitIdx;
         do begin
            @(posedge clk);
            budget++;
         end while (digitIdx === idxSnap && budget < 50);
      end
      #3;
      checkOutput("preResetData", (fndData != 8'hFF), 1);
      rst_n = 1'b0;
      monOn = 0;
      #1;
      checkOutput("midResetCom", fndCom, 4'hF);
      checkOutput("midResetData", fndData, 8'hFF);
      checkOutput("midResetFrameDone", frameDone, 0);
      checkOutput("midResetIdx", digitIdx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      qFrame.delete();
      qPat.delete();
      curPat = 32'hC0C0C0C0;
      frameNum = 0;
      haveFrame = 0;
      armed = 0;
      prevData = fndData; prevCom = fndCom; prevIdx = digitIdx;
      monOn = 1;
      waitFrames(3);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
